// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and the bus events decoded from filtered SCL/SDA.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_STOP,
    EV_SCL_RISE,
    EV_SCL_FALL
  } i2c_event_e;

  localparam logic [3:0] BYTE_BITS = 4'd8;

  // START/STOP take priority over clock edges so they override any state.
  function automatic i2c_event_e decode_event(input logic scl_f,
                                              input logic scl_rise,
                                              input logic scl_fall,
                                              input logic sda_rise,
                                              input logic sda_fall);
    if (scl_f && sda_fall)      return EV_START;
    else if (scl_f && sda_rise) return EV_STOP;
    else if (scl_rise)          return EV_SCL_RISE;
    else if (scl_fall)          return EV_SCL_FALL;
    else                        return EV_NONE;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchronizer plus FILT-cycle persistence filter and edge detect for one bus line.
module i2c_in_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl_q;
  logic          lvl_d1;

  // Idle bus level is high, so the filter comes out of reset released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      cnt    <= '0;
      lvl_q  <= 1'b1;
      lvl_d1 <= 1'b1;
    end else begin
      sync   <= {sync[0], din};
      lvl_d1 <= lvl_q;
      if (sync[1] == lvl_q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        lvl_q <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~lvl_d1;
  assign fall = ~lvl_q & lvl_d1;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with 7-bit address match and an auto-incrementing register pointer
// driving a one-cycle write/read strobe interface to local registers.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h42,
  parameter int         AW    = 4,
  parameter int         NREGS = 16,
  parameter int         FILT  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_t,
  input  logic          scl_i,
  output logic          scl_o,
  output logic          scl_t,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_stb,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (int'(p) == NREGS - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_from_byte(input logic [7:0] b);
    return (int'(b[AW-1:0]) >= NREGS) ? '0 : b[AW-1:0];
  endfunction

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_in_filter #(.FILT(FILT)) u_scl_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (scl_i),
    .lvl  (scl_f),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_in_filter #(.FILT(FILT)) u_sda_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sda_i),
    .lvl  (sda_f),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  i2c_event_e ev;
  i2c_state_e state, state_d;

  logic [3:0]    bit_cnt;
  logic [7:0]    sr;
  logic [AW-1:0] ptr;
  logic          rd_vld_p1;

  logic bit_clr, bit_inc, shift_en, tx_shift, drive_ack, release_sda;
  logic wr_fire, rd_fire, ptr_load, ptr_inc, busy_set, busy_clr;

  assign ev    = decode_event(scl_f, scl_rise, scl_fall, sda_rise, sda_fall);
  assign sda_o = 1'b0;
  assign scl_o = 1'b1;
  assign scl_t = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    shift_en    = 1'b0;
    tx_shift    = 1'b0;
    drive_ack   = 1'b0;
    release_sda = 1'b0;
    wr_fire     = 1'b0;
    rd_fire     = 1'b0;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    busy_set    = 1'b0;
    busy_clr    = 1'b0;
    case (ev)
      EV_START: begin
        state_d     = ST_ADDR;
        bit_clr     = 1'b1;
        release_sda = 1'b1;
        busy_clr    = 1'b1;
      end
      EV_STOP: begin
        state_d     = ST_IDLE;
        bit_clr     = 1'b1;
        release_sda = 1'b1;
        busy_clr    = 1'b1;
      end
      EV_SCL_RISE: begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            shift_en = 1'b1;
            bit_inc  = 1'b1;
          end
          ST_RDATA: bit_inc = 1'b1;
          ST_RACK: begin
            if (sda_f) begin
              state_d  = ST_IGNORE;
              busy_clr = 1'b1;
            end else begin
              ptr_inc = 1'b1;
            end
          end
          default: ;
        endcase
      end
      EV_SCL_FALL: begin
        case (state)
          ST_ADDR: begin
            if (bit_cnt == BYTE_BITS) begin
              bit_clr = 1'b1;
              if (sr[7:1] == ADDR) begin
                drive_ack = 1'b1;
                busy_set  = 1'b1;
                state_d   = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            release_sda = 1'b1;
            if (sr[0]) begin
              rd_fire = 1'b1;
              state_d = ST_RDATA;
            end else begin
              state_d = ST_PTR;
            end
          end
          ST_PTR: begin
            if (bit_cnt == BYTE_BITS) begin
              bit_clr   = 1'b1;
              ptr_load  = 1'b1;
              drive_ack = 1'b1;
              state_d   = ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: begin
            release_sda = 1'b1;
            state_d     = ST_WDATA;
          end
          ST_WDATA: begin
            if (bit_cnt == BYTE_BITS) begin
              bit_clr   = 1'b1;
              wr_fire   = 1'b1;
              drive_ack = 1'b1;
              state_d   = ST_WACK;
            end
          end
          ST_WACK: begin
            release_sda = 1'b1;
            ptr_inc     = 1'b1;
            state_d     = ST_WDATA;
          end
          ST_RDATA: begin
            if (bit_cnt == BYTE_BITS) begin
              bit_clr     = 1'b1;
              release_sda = 1'b1;
              state_d     = ST_RACK;
            end else begin
              tx_shift = 1'b1;
            end
          end
          ST_RACK: begin
            rd_fire = 1'b1;
            state_d = ST_RDATA;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // p0: strobes issued; p1: rd_data valid and loaded into the shifter with its MSB driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_t     <= 1'b1;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      sr        <= '0;
      ptr       <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      wr_stb    <= wr_fire;
      rd_stb    <= rd_fire;
      rd_vld_p1 <= rd_stb;

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

      if (rd_vld_p1 && state == ST_RDATA) begin
        sr    <= rd_data;
        sda_t <= rd_data[7];
      end
      if (shift_en) sr <= {sr[6:0], sda_f};
      if (tx_shift) begin
        sr    <= {sr[6:0], 1'b0};
        sda_t <= sr[6];
      end
      if (drive_ack)   sda_t <= 1'b0;
      if (release_sda) sda_t <= 1'b1;

      if (ptr_load)     ptr <= ptr_from_byte(sr);
      else if (ptr_inc) ptr <= ptr_next(ptr);

      if (wr_fire) begin
        wr_addr <= ptr;
        wr_data <= sr;
      end
      if (rd_fire) rd_addr <= ptr;

      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench: an I2C master model drives random and directed transactions against a register-file reference.
module tb_i2c_target_regs;

  localparam int Q     = 8;
  localparam int FILT  = 3;
  localparam int AW    = 4;
  localparam int NREGS = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          sda_i, scl_i, sda_o, sda_t, scl_o, scl_t;
  logic          wr_stb, rd_stb, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data = 8'h00;

  assign sda_i = m_sda & (sda_t | sda_o);
  assign scl_i = m_scl & (scl_t | scl_o);

  i2c_target_regs #(.ADDR(7'h42), .AW(AW), .NREGS(NREGS), .FILT(FILT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sda_i  (sda_i),
    .sda_o  (sda_o),
    .sda_t  (sda_t),
    .scl_i  (scl_i),
    .scl_o  (scl_o),
    .scl_t  (scl_t),
    .wr_stb (wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_stb (rd_stb),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Emulated local register file (1-cycle read latency) plus strobe logs.
  logic [7:0]  mem [NREGS];
  bit          mem_rdy = 1'b0;
  logic [11:0] wr_log [1024];
  logic [3:0]  rd_log [1024];
  int          wr_n = 0, rd_n = 0, drv_n = 0, busy_n = 0;

  always @(posedge clk) begin
    if (!mem_rdy) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= 8'(i) ^ 8'hA0;
      mem_rdy <= 1'b1;
    end else if (wr_stb) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_stb) rd_data <= mem[rd_addr];
    if (wr_stb) begin
      wr_log[wr_n % 1024] <= {wr_addr, wr_data};
      wr_n <= wr_n + 1;
    end
    if (rd_stb) begin
      rd_log[rd_n % 1024] <= rd_addr;
      rd_n <= rd_n + 1;
    end
    if (!sda_t) drv_n <= drv_n + 1;
    if (busy)   busy_n <= busy_n + 1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and pointer as the master should see them.
  logic [7:0] mregs [NREGS];
  int         mptr;
  logic [7:0] wdat [8];

  function automatic int ptr_of(input logic [7:0] b);
    int v;
    v = int'(b) % (1 << AW);
    return (v >= NREGS) ? 0 : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
    end
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b; tick(Q);
    m_scl = 1'b1;
    if (glitch) begin
      tick(Q);
      m_scl = 1'b0; tick(FILT - 1);
      m_scl = 1'b1; tick(Q - (FILT - 1));
    end else begin
      tick(2 * Q);
    end
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = sda_i;    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic acked);
    logic b;
    for (int i = 0; i < 8; i++) send_bit(d[7-i], i == gbit);
    recv_bit(b);
    acked = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack, 1'b0);
  endtask

  task automatic txn_write(input logic [7:0] pb, input int n, input int gbyte, input int gbit);
    logic       a;
    int         w0;
    logic [3:0] ea [8];
    logic [7:0] ed [8];
    w0 = wr_n;
    bus_start();
    send_byte(8'h84, -1, a); chk("w_addr_ack", a, 1);
    send_byte(pb, -1, a);    chk("w_ptr_ack", a, 1);
    mptr = ptr_of(pb);
    for (int i = 0; i < n; i++) begin
      send_byte(wdat[i], (i == gbyte) ? gbit : -1, a);
      chk("w_data_ack", a, 1);
      ea[i] = 4'(mptr);
      ed[i] = wdat[i];
      mregs[mptr] = wdat[i];
      mptr = (mptr + 1) % NREGS;
    end
    chk("w_busy", busy, 1);
    bus_stop();
    chk("w_busy_stop", busy, 0);
    chk("w_count", wr_n - w0, n);
    for (int i = 0; i < n; i++) begin
      chk("w_addr", wr_log[(w0 + i) % 1024][11:8], ea[i]);
      chk("w_data", wr_log[(w0 + i) % 1024][7:0], ed[i]);
    end
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] pb, input int n);
    logic       a;
    logic [7:0] d;
    int         r0;
    logic [3:0] ea [8];
    r0 = rd_n;
    bus_start();
    if (set_ptr) begin
      send_byte(8'h84, -1, a); chk("r_waddr_ack", a, 1);
      send_byte(pb, -1, a);    chk("r_ptr_ack", a, 1);
      mptr = ptr_of(pb);
      bus_start();
    end
    send_byte(8'h85, -1, a); chk("r_addr_ack", a, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i == n - 1);
      chk("r_data", d, mregs[mptr]);
      ea[i] = 4'(mptr);
      if (i != n - 1) mptr = (mptr + 1) % NREGS;
    end
    chk("r_nack_release", sda_t, 1);
    chk("r_nack_busy", busy, 0);
    bus_stop();
    chk("r_count", rd_n - r0, n);
    for (int i = 0; i < n; i++) chk("r_addr", rd_log[(r0 + i) % 1024], ea[i]);
  endtask

  task automatic txn_miss(input logic [6:0] a7, input logic rw);
    logic a;
    int   d0, b0, w0, r0;
    d0 = drv_n; b0 = busy_n; w0 = wr_n; r0 = rd_n;
    bus_start();
    send_byte({a7, rw}, -1, a);          chk("m_addr_nack", a, 0);
    send_byte(8'($urandom), -1, a);      chk("m_data_nack", a, 0);
    bus_stop();
    chk("m_sda_driven", drv_n - d0, 0);
    chk("m_busy", busy_n - b0, 0);
    chk("m_strobes", (wr_n - w0) + (rd_n - r0), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] ab;
    logic [6:0] a7;
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'(i) ^ 8'hA0;
    mptr = 0;

    tick(3);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_rd_stb", rd_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_scl_t", scl_t, 1);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_sda_o", sda_o, 0);
    rst_n = 1'b1;
    tick(4);

    // Read two bytes from pointer 3 via repeated START; NACK on the second.
    txn_read(1'b1, 8'h03, 2);

    // Single write of 0x5A to register 3.
    wdat[0] = 8'h5A;
    txn_write(8'h03, 1, -1, 0);

    // Wrong address 0x86 (7'h43, write).
    txn_miss(7'h43, 1'b0);

    // Pointer wrap 15 -> 0, then pointer byte 0x14 selects register 4.
    wdat[0] = 8'h11; wdat[1] = 8'h22;
    txn_write(8'h0F, 2, -1, 0);
    txn_write(8'h14, 0, -1, 0);
    txn_read(1'b0, 8'h00, 1);

    // Short SCL low glitch inside a data bit.
    wdat[0] = 8'h5A;
    txn_write(8'h07, 1, 0, 3);

    // Reset while the address ACK is being driven.
    ab = 8'h84;
    bus_start();
    for (int i = 0; i < 8; i++) send_bit(ab[7-i], 1'b0);
    chk("rst_ack_driven", sda_t, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_release", sda_t, 1);
    chk("rst_async_busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    mptr = 0;
    tick(2);
    bus_stop();
    chk("rst_wr_addr2", wr_addr, 0);
    chk("rst_rd_addr2", rd_addr, 0);
    txn_read(1'b0, 8'h00, 1);

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom);
          txn_write(8'($urandom), int'($urandom_range(1, 4)),
                    ($urandom_range(0, 1) == 1) ? 0 : -1, int'($urandom_range(0, 7)));
        end
        1: txn_read(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 4)));
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h42) a7 = a7 ^ 7'h01;
          txn_miss(a7, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
